// File: rtl/dbf_ch_gen.sv
// One beamformer receive channel: coarse delay from a circular sample buffer
// addressed through a focal-zone LUT, linear-interpolation fine delay, apodisation.
module dbf_ch_gen #(
  parameter int unsigned INPUT_WD  = 14,
  parameter int unsigned APO_WD    = 16,
  parameter int unsigned ADDR_WD   = 8,
  parameter int unsigned CD_AW     = 10,
  parameter int unsigned FRAC_WD   = 3,
  parameter int unsigned OUT_SHIFT = 15,
  parameter int unsigned OUT_WD    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tx_en,
  input  logic                      start,
  input  logic [INPUT_WD-1:0]       ch_in,
  input  logic [APO_WD-1:0]         apo_din,
  input  logic [ADDR_WD-1:0]        lut_addr,
  input  logic                      lut_we,
  input  logic [CD_AW+FRAC_WD-1:0]  lut_wdata,
  input  logic                      zone_adv,
  output logic [OUT_WD-1:0]         dbf_ch_dout,
  output logic                      dbf_ch_dout_valid,
  output logic [INPUT_WD-1:0]       cd_dout,
  output logic                      sat_flag
);

  localparam int unsigned LUT_WD = CD_AW + FRAC_WD;
  localparam int unsigned WGT_WD = FRAC_WD + 2;
  localparam int unsigned IW     = INPUT_WD + WGT_WD;
  localparam int unsigned PW     = INPUT_WD + APO_WD;
  localparam int unsigned SW     = ((PW > OUT_WD) ? PW : OUT_WD) + 1;

  localparam logic [CD_AW:0]        FILL_MAX = {1'b1, {CD_AW{1'b0}}};
  localparam logic signed [IW-1:0]  RND      = IW'(1) << (FRAC_WD - 1);
  localparam logic signed [SW-1:0]  SAT_MAX  = {{(SW-OUT_WD+1){1'b0}}, {(OUT_WD-1){1'b1}}};
  localparam logic signed [SW-1:0]  SAT_MIN  = ~SAT_MAX;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_nxt;
  logic   start_q;

  logic [CD_AW-1:0]   wr_ptr;
  logic [CD_AW:0]     fill_cnt;
  logic [ADDR_WD-1:0] zone_idx;

  logic [INPUT_WD-1:0] buf_mem [2**CD_AW];
  logic [LUT_WD-1:0]   lut_mem [2**ADDR_WD];

  logic start_rise_c, leave_c, acc_c, underfill_c;
  logic [LUT_WD-1:0]  lut_ent_c;
  logic [CD_AW-1:0]   coarse_c, rd0_c, rd1_c;
  logic [FRAC_WD-1:0] frac_c;

  logic                       s1_vld, s2_vld, s3_vld;
  logic signed [INPUT_WD-1:0] s1_x0, s1_x1, s2_interp;
  logic [FRAC_WD-1:0]         s1_f;
  logic signed [APO_WD-1:0]   s1_apo, s2_apo;
  logic signed [PW-1:0]       s3_prod;

  logic signed [WGT_WD-1:0]   wgt0_c, wgt1_c;
  logic signed [IW-1:0]       sum_c;
  logic signed [INPUT_WD-1:0] interp_c;
  logic signed [PW-1:0]       prod_c, sh_c;
  logic signed [SW-1:0]       ext_c;
  logic [OUT_WD-1:0]          sat_val_c;
  logic                       clamp_c;

  assign start_rise_c = start & ~start_q;
  assign leave_c      = (state == RUN) & ~start;
  assign acc_c        = start & ~tx_en & (state == RUN);

  // Receive window FSM
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_rise_c) state_nxt = RUN;
      RUN:     if (!start)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      zone_idx <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      if (start_rise_c) begin
        wr_ptr   <= '0;
        fill_cnt <= '0;
        zone_idx <= '0;
      end else begin
        if (acc_c) begin
          wr_ptr <= wr_ptr + CD_AW'(1);
          if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + (CD_AW+1)'(1);
        end
        if (zone_adv && (state == RUN) && (zone_idx != '1)) zone_idx <= zone_idx + ADDR_WD'(1);
      end
    end
  end

  // Storage arrays are not reset; the fill counter guards stale buffer data
  always_ff @(posedge clk) begin
    if (acc_c) buf_mem[wr_ptr] <= ch_in;
  end

  always_ff @(posedge clk) begin
    if (lut_we) lut_mem[lut_addr] <= lut_wdata;
  end

  // S1 address generation; reads see pre-write buffer contents
  always_comb begin
    lut_ent_c   = lut_mem[zone_idx];
    coarse_c    = lut_ent_c[LUT_WD-1:FRAC_WD];
    frac_c      = lut_ent_c[FRAC_WD-1:0];
    rd0_c       = wr_ptr - CD_AW'(1) - coarse_c;
    rd1_c       = rd0_c - CD_AW'(1);
    underfill_c = fill_cnt <= ((CD_AW+1)'(coarse_c) + (CD_AW+1)'(1));
  end

  // Interpolation, apodisation and output saturation
  always_comb begin
    wgt1_c    = WGT_WD'(s1_f);
    wgt0_c    = WGT_WD'(2 ** FRAC_WD) - WGT_WD'(s1_f);
    sum_c     = IW'(s1_x0) * IW'(wgt0_c) + IW'(s1_x1) * IW'(wgt1_c) + RND;
    interp_c  = INPUT_WD'(sum_c >>> FRAC_WD);
    prod_c    = PW'(s2_interp) * PW'(s2_apo);
    sh_c      = s3_prod >>> OUT_SHIFT;
    ext_c     = SW'(sh_c);
    clamp_c   = 1'b0;
    sat_val_c = OUT_WD'(ext_c);
    if (ext_c > SAT_MAX) begin
      clamp_c   = 1'b1;
      sat_val_c = OUT_WD'(SAT_MAX);
    end else if (ext_c < SAT_MIN) begin
      clamp_c   = 1'b1;
      sat_val_c = OUT_WD'(SAT_MIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld            <= 1'b0;
      s2_vld            <= 1'b0;
      s3_vld            <= 1'b0;
      s1_x0             <= '0;
      s1_x1             <= '0;
      s1_f              <= '0;
      s1_apo            <= '0;
      s2_interp         <= '0;
      s2_apo            <= '0;
      s3_prod           <= '0;
      dbf_ch_dout       <= '0;
      dbf_ch_dout_valid <= 1'b0;
      cd_dout           <= '0;
      sat_flag          <= 1'b0;
    end else begin
      s1_vld            <= acc_c;
      s2_vld            <= s1_vld & ~leave_c;
      s3_vld            <= s2_vld & ~leave_c;
      dbf_ch_dout_valid <= s3_vld & ~leave_c;
      if (acc_c) begin
        s1_x0  <= underfill_c ? '0 : buf_mem[rd0_c];
        s1_x1  <= underfill_c ? '0 : buf_mem[rd1_c];
        s1_f   <= frac_c;
        s1_apo <= apo_din;
      end
      if (s1_vld) begin
        s2_interp <= interp_c;
        s2_apo    <= s1_apo;
      end
      if (s1_vld && !leave_c) cd_dout <= s1_x0;
      if (s2_vld) s3_prod <= prod_c;
      if (leave_c) dbf_ch_dout <= '0;
      else if (s3_vld) dbf_ch_dout <= sat_val_c;
      if (start_rise_c) sat_flag <= 1'b0;
      else if (s3_vld && !leave_c && clamp_c) sat_flag <= 1'b1;
    end
  end

endmodule
